// File: rtl/vx_commit_profiler.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_profiler
// Brief    : Commit-stage thread counter plus per-warp PC-delimited timing
//            windows with saturating cycle/thread counters for the CSR unit.
// Revision : 1.0 - initial release
// ============================================================================
module vx_commit_profiler #(
    parameter int NUM_CHANNELS = 6,
    parameter int NUM_THREADS  = 4,
    parameter int NUM_WARPS    = 4,
    parameter int NUM_WINDOWS  = 2,
    parameter int CNT_W        = 48,
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int SIZE_W      = $clog2(NUM_CHANNELS * NUM_THREADS + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             cmt_fire,
    input  logic [NUM_CHANNELS*32-1:0]          cmt_pc,
    input  logic [NUM_CHANNELS*NW_BITS-1:0]     cmt_wid,
    input  logic [NUM_CHANNELS*NUM_THREADS-1:0] cmt_tmask,
    input  logic [NUM_WINDOWS-1:0]              win_enable,
    input  logic [NUM_WINDOWS*32-1:0]           win_start_addr,
    input  logic [NUM_WINDOWS*32-1:0]           win_end_addr,
    input  logic                                prof_clear,
    output logic                                commit_valid,
    output logic [SIZE_W-1:0]                   commit_size,
    output logic [NUM_WINDOWS*NUM_WARPS-1:0]    win_active,
    output logic [NUM_WINDOWS*CNT_W-1:0]        win_cycles,
    output logic [NUM_WINDOWS*CNT_W-1:0]        win_threads
);
    localparam int c_sum_w = CNT_W + 1;

    logic [SIZE_W-1:0]                         w_pop [NUM_CHANNELS];
    logic [NW_BITS-1:0]                        w_wid [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                   w_wid_ok;
    logic [SIZE_W-1:0]                         w_size;
    logic [NUM_WINDOWS-1:0][NUM_WARPS-1:0]     w_start_hit;
    logic [NUM_WINDOWS-1:0][NUM_WARPS-1:0]     w_end_hit;
    logic [NUM_WINDOWS-1:0][NUM_WARPS-1:0]     w_arm;
    logic [NUM_WINDOWS-1:0][NUM_WARPS-1:0]     w_active_nxt;
    logic [SIZE_W-1:0]                         w_thr_inc [NUM_WINDOWS];
    logic [CNT_W:0]                            w_cyc_sum [NUM_WINDOWS];
    logic [CNT_W:0]                            w_thr_sum [NUM_WINDOWS];
    logic [CNT_W-1:0]                          w_cyc_nxt [NUM_WINDOWS];
    logic [CNT_W-1:0]                          w_thr_nxt [NUM_WINDOWS];

    logic                                      r_commit_valid;
    logic [SIZE_W-1:0]                         r_commit_size;
    logic [NUM_WINDOWS-1:0][NUM_WARPS-1:0]     r_active;
    logic [CNT_W-1:0]                          r_cycles  [NUM_WINDOWS];
    logic [CNT_W-1:0]                          r_threads [NUM_WINDOWS];

    // Per-channel decode: masked thread count and warp-id validity
    always_comb begin
        w_size = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_wid[i]    = cmt_wid[i*NW_BITS +: NW_BITS];
            w_wid_ok[i] = int'(w_wid[i]) < NUM_WARPS;
            w_pop[i]    = '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                w_pop[i] = w_pop[i] + SIZE_W'(cmt_tmask[i*NUM_THREADS + t]);
            end
            if (cmt_fire[i]) begin
                w_size = w_size + w_pop[i];
            end
        end
    end

    // Window hit detection and thread increments use the registered state
    always_comb begin
        w_start_hit = '0;
        w_end_hit   = '0;
        for (int w = 0; w < NUM_WINDOWS; w++) begin
            w_arm[w]     = {NUM_WARPS{win_enable[w]}};
            w_thr_inc[w] = '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (cmt_fire[i] && w_wid_ok[i]) begin
                    if (cmt_pc[i*32 +: 32] == win_start_addr[w*32 +: 32]) begin
                        w_start_hit[w][w_wid[i]] = 1'b1;
                    end
                    if (cmt_pc[i*32 +: 32] == win_end_addr[w*32 +: 32]) begin
                        w_end_hit[w][w_wid[i]] = 1'b1;
                    end
                    if (r_active[w][w_wid[i]]) begin
                        w_thr_inc[w] = w_thr_inc[w] + w_pop[i];
                    end
                end
            end
        end
        // End always wins over start, even when both addresses coincide
        w_active_nxt = (r_active & ~w_end_hit) | (w_start_hit & ~w_end_hit & w_arm);
    end

    // Saturating counters: carry out of the widened sum pins the value at all-ones
    always_comb begin
        for (int w = 0; w < NUM_WINDOWS; w++) begin
            w_cyc_sum[w] = {1'b0, r_cycles[w]} + c_sum_w'(|r_active[w]);
            w_thr_sum[w] = {1'b0, r_threads[w]} + c_sum_w'(w_thr_inc[w]);
            w_cyc_nxt[w] = w_cyc_sum[w][CNT_W] ? '1 : w_cyc_sum[w][CNT_W-1:0];
            w_thr_nxt[w] = w_thr_sum[w][CNT_W] ? '1 : w_thr_sum[w][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_commit_valid <= 1'b0;
            r_commit_size  <= '0;
            r_active       <= '0;
            for (int w = 0; w < NUM_WINDOWS; w++) begin
                r_cycles[w]  <= '0;
                r_threads[w] <= '0;
            end
        end else begin
            r_commit_valid <= |cmt_fire;
            r_commit_size  <= w_size;
            if (prof_clear) begin
                r_active <= '0;
                for (int w = 0; w < NUM_WINDOWS; w++) begin
                    r_cycles[w]  <= '0;
                    r_threads[w] <= '0;
                end
            end else begin
                r_active <= w_active_nxt;
                for (int w = 0; w < NUM_WINDOWS; w++) begin
                    r_cycles[w]  <= w_cyc_nxt[w];
                    r_threads[w] <= w_thr_nxt[w];
                end
            end
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_size  = r_commit_size;
    assign win_active   = r_active;

    for (genvar w = 0; w < NUM_WINDOWS; w++) begin : g_out
        assign win_cycles[w*CNT_W +: CNT_W]  = r_cycles[w];
        assign win_threads[w*CNT_W +: CNT_W] = r_threads[w];
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_commit_profiler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_commit_profiler
// Brief    : Directed self-checking bench for vx_commit_profiler (CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_commit_profiler;
    localparam int NCH = 6, NT = 4, NWP = 4, NWIN = 2, CW = 8, NWB = 2, SW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       cmt_fire;
    logic [NCH*32-1:0]    cmt_pc;
    logic [NCH*NWB-1:0]   cmt_wid;
    logic [NCH*NT-1:0]    cmt_tmask;
    logic [NWIN-1:0]      win_enable;
    logic [NWIN*32-1:0]   win_start_addr;
    logic [NWIN*32-1:0]   win_end_addr;
    logic                 prof_clear;
    logic                 commit_valid;
    logic [SW-1:0]        commit_size;
    logic [NWIN*NWP-1:0]  win_active;
    logic [NWIN*CW-1:0]   win_cycles;
    logic [NWIN*CW-1:0]   win_threads;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vx_commit_profiler #(
        .NUM_CHANNELS(NCH), .NUM_THREADS(NT), .NUM_WARPS(NWP),
        .NUM_WINDOWS(NWIN), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmt_fire(cmt_fire), .cmt_pc(cmt_pc), .cmt_wid(cmt_wid), .cmt_tmask(cmt_tmask),
        .win_enable(win_enable), .win_start_addr(win_start_addr), .win_end_addr(win_end_addr),
        .prof_clear(prof_clear),
        .commit_valid(commit_valid), .commit_size(commit_size),
        .win_active(win_active), .win_cycles(win_cycles), .win_threads(win_threads)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cmt_fire   = '0;
        cmt_pc     = '0;
        cmt_wid    = '0;
        cmt_tmask  = '0;
        prof_clear = 1'b0;
    endtask

    task automatic fire(input int ch, input logic [31:0] pc, input logic [1:0] wid,
                        input logic [3:0] tm);
        cmt_fire[ch]          = 1'b1;
        cmt_pc[ch*32 +: 32]   = pc;
        cmt_wid[ch*NWB +: NWB] = wid;
        cmt_tmask[ch*NT +: NT] = tm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        win_enable     = '0;
        win_start_addr = '0;
        win_end_addr   = '0;
        idle();
        tick();
        tick();
        chk("rst_valid",   {63'd0, commit_valid}, 64'd0);
        chk("rst_size",    {59'd0, commit_size}, 64'd0);
        chk("rst_active",  {56'd0, win_active}, 64'd0);
        chk("rst_cycles",  {48'd0, win_cycles}, 64'd0);
        chk("rst_threads", {48'd0, win_threads}, 64'd0);
        reset = 1'b1;

        // Commit counting
        idle(); fire(0, 32'h0, 2'd0, 4'b1011); tick();
        chk("single_valid", {63'd0, commit_valid}, 64'd1);
        chk("single_size",  {59'd0, commit_size}, 64'd3);
        idle(); tick();
        chk("idle_valid", {63'd0, commit_valid}, 64'd0);
        chk("idle_size",  {59'd0, commit_size}, 64'd0);
        idle(); for (int c = 0; c < NCH; c++) fire(c, 32'h40, 2'd1, 4'b1111); tick();
        chk("full_size", {59'd0, commit_size}, 64'd24);
        idle(); for (int c = 0; c < NCH; c++) fire(c, 32'h40, 2'd1, 4'b0101); tick();
        chk("alt_size", {59'd0, commit_size}, 64'd12);

        // Window 0 on warp 2: 0x100 .. 0x180
        win_start_addr[31:0] = 32'h100;
        win_end_addr[31:0]   = 32'h180;
        win_enable = 2'b01;
        idle(); fire(0, 32'h100, 2'd2, 4'b1111); tick();
        chk("win_rise",      {56'd0, win_active}, 64'h04);
        chk("win_start_thr", {56'd0, win_threads[7:0]}, 64'd0);
        idle(); fire(0, 32'h104, 2'd2, 4'b1111); tick();
        idle(); fire(1, 32'h104, 2'd1, 4'b1111); tick();
        idle(); fire(0, 32'h108, 2'd2, 4'b1111); tick();
        idle(); tick();
        idle(); fire(0, 32'h10c, 2'd2, 4'b1111); tick();
        chk("win_mid_thr", {56'd0, win_threads[7:0]}, 64'd12);
        chk("win_mid_cyc", {56'd0, win_cycles[7:0]}, 64'd5);
        idle(); fire(0, 32'h180, 2'd2, 4'b0011); tick();
        chk("win_fall",    {56'd0, win_active}, 64'h00);
        chk("win_end_thr", {56'd0, win_threads[7:0]}, 64'd14);
        chk("win_end_cyc", {56'd0, win_cycles[7:0]}, 64'd6);
        idle(); tick();
        chk("win_hold_cyc", {56'd0, win_cycles[7:0]}, 64'd6);
        chk("win1_idle",    {48'd0, win_threads[15:8], win_cycles[15:8]}, 64'd0);

        // End beats start; disabled window and start==end never activate
        idle(); fire(1, 32'h100, 2'd2, 4'b1111); fire(4, 32'h180, 2'd2, 4'b1111); tick();
        chk("same_cyc_a", {56'd0, win_active}, 64'h00);
        idle(); fire(1, 32'h180, 2'd2, 4'b1111); fire(4, 32'h100, 2'd2, 4'b1111); tick();
        chk("same_cyc_b", {56'd0, win_active}, 64'h00);
        chk("same_cyc_thr", {56'd0, win_threads[7:0]}, 64'd14);
        win_enable = 2'b00;
        idle(); fire(0, 32'h100, 2'd2, 4'b1111); tick();
        chk("disabled", {56'd0, win_active}, 64'h00);
        win_start_addr[63:32] = 32'h200;
        win_end_addr[63:32]   = 32'h200;
        win_enable = 2'b10;
        idle(); fire(2, 32'h200, 2'd1, 4'b1111); tick();
        chk("start_eq_end", {56'd0, win_active}, 64'h00);

        // Saturation
        idle(); prof_clear = 1'b1; tick();
        chk("clear_cnt", {32'd0, win_cycles, win_threads}, 64'd0);
        win_enable = 2'b01;
        idle(); fire(0, 32'h100, 2'd2, 4'b1111); tick();
        chk("sat_rise", {56'd0, win_active}, 64'h04);
        for (int n = 0; n < 12; n++) begin
            idle();
            for (int c = 0; c < NCH; c++) fire(c, 32'h104, 2'd2, 4'b1111);
            tick();
        end
        chk("sat_thr", {56'd0, win_threads[7:0]}, 64'd255);
        chk("sat_cyc", {56'd0, win_cycles[7:0]}, 64'd12);
        idle(); for (int c = 0; c < NCH; c++) fire(c, 32'h104, 2'd2, 4'b1111); tick();
        chk("sat_hold", {56'd0, win_threads[7:0]}, 64'd255);
        idle(); prof_clear = 1'b1; fire(3, 32'h100, 2'd1, 4'b1111); tick();
        chk("clr_active",  {56'd0, win_active}, 64'h00);
        chk("clr_counts",  {32'd0, win_cycles, win_threads}, 64'd0);
        chk("clr_commit",  {58'd0, commit_valid, commit_size}, {58'd0, 1'b1, 5'd4});

        // Asynchronous reset mid-window
        idle(); fire(0, 32'h100, 2'd0, 4'b1111); tick();
        chk("ar_rise", {56'd0, win_active}, 64'h01);
        idle(); tick();
        idle(); fire(5, 32'h300, 2'd1, 4'b0001); tick();
        chk("ar_pre_cyc", {56'd0, win_cycles[7:0]}, 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid",  {63'd0, commit_valid}, 64'd0);
        chk("ar_active", {56'd0, win_active}, 64'd0);
        chk("ar_counts", {32'd0, win_cycles, win_threads}, 64'd0);
        reset = 1'b1;
        idle(); tick(); tick();
        chk("ar_post_idle", {48'd0, win_active, win_cycles[7:0]}, 64'd0);
        idle(); fire(0, 32'h100, 2'd3, 4'b1111); tick();
        chk("ar_restart", {56'd0, win_active}, 64'h08);
        idle(); tick();
        chk("ar_resume", {48'd0, win_cycles[7:0], win_threads[7:0]}, {48'd0, 8'd1, 8'd0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_commit_profiler.md
# vx_commit_profiler

Parametrised commit-stage aggregator and profiler for the Vortex core, placed beside the writeback path and feeding the CSR unit. It accepts NUM_CHANNELS commit fire strobes per cycle and produces a registered per-cycle committed-thread count for the CSR instret logic. It also tracks NUM_WINDOWS independent per-warp PC-delimited "timeit" windows. For each window it keeps saturating active-cycle and committed-thread counters readable by the CSR unit.

## Interface
Parameters:
- NUM_CHANNELS, 6, commit channels (ALU, LD, ST, CSR, FPU, GPU order is the integrator's choice)
- NUM_THREADS, 4, threads per warp
- NUM_WARPS, 4, warps per core
- NUM_WINDOWS, 2, independent timing windows
- CNT_W, 48, width of profiling counters
- Derived: NW_BITS = max(1, clog2(NUM_WARPS)); SIZE_W = clog2(NUM_CHANNELS*NUM_THREADS+1)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- cmt_fire  in  NUM_CHANNELS  channel i committed this cycle (valid && ready)
- cmt_pc  in  NUM_CHANNELS*32  PC per channel
- cmt_wid  in  NUM_CHANNELS*NW_BITS  warp id per channel
- cmt_tmask  in  NUM_CHANNELS*NUM_THREADS  thread mask per channel
- win_enable  in  NUM_WINDOWS  window w armed
- win_start_addr  in  NUM_WINDOWS*32  start PC per window
- win_end_addr  in  NUM_WINDOWS*32  end PC per window
- prof_clear  in  1  synchronous clear of all windows and counters
- commit_valid  out  1  registered: any channel fired last cycle
- commit_size  out  SIZE_W  registered: popcount of fired tmasks last cycle
- win_active  out  NUM_WINDOWS*NUM_WARPS  per-window, per-warp active state
- win_cycles  out  NUM_WINDOWS*CNT_W  cycles with at least one warp active in window
- win_threads  out  NUM_WINDOWS*CNT_W  thread-instructions committed inside window

## Operation
- Commit count: size = popcount over all channels of ({NUM_THREADS{cmt_fire[i]}} & tmask_i). Registered with commit_valid = |cmt_fire.
- Per window w, per warp k, a 1-bit state IDLE/ACTIVE is kept, stored in win_active.
- start_hit[w][k]: any channel i has fire, wid==k and pc==start_addr[w]. end_hit is defined the same way with end_addr[w].
- Next state: end_hit → IDLE; else start_hit && win_enable[w] → ACTIVE; else hold. End beats start regardless of channel order, including the case start_addr==end_addr.
- Deasserting win_enable does not clear ACTIVE; only end_hit, prof_clear or reset do.
- win_cycles[w] increments when |win_active[w] (registered state) is true.
- win_threads[w] adds popcount(tmask_i) for every firing channel i whose warp is ACTIVE in window w in the registered state.
  - An instruction at the start PC is therefore not counted.
  - An instruction at the end PC is counted.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Per-cycle increments are at most NUM_CHANNELS*NUM_THREADS, zero-extended to CNT_W.
- prof_clear forces all win_active, win_cycles and win_threads to 0 next cycle and overrides same-cycle hits and increments. It does not affect commit_valid/commit_size.
- Out-of-range wid values (≥ NUM_WARPS) are ignored for window state. Their threads still count in commit_size.

## Timing
- Reset (reset=0, asynchronous): commit_valid=0, commit_size=0, win_active=0, win_cycles=0, win_threads=0. Release is synchronous to clk.
- commit_valid/commit_size: 1-cycle latency from cmt_fire.
- win_active: updates at the clock edge after the hitting commit.
- win_cycles/win_threads: reflect the cycle-N state at edge N+1, giving 1-cycle latency.
- No backpressure: every cycle's inputs are consumed; the block never stalls commit.
- Reset asserted mid-window drops all state immediately, without waiting for a clock.

## Test plan
- Single channel 0 fires, tmask=4'b1011; other channels idle → next cycle commit_valid=1, commit_size=3; cycle after, commit_valid=0, size=0.
- All 6 channels fire with full masks (NUM_THREADS=4) → commit_size=24; repeat with alternating masks 4'b0101 → 12.
- Window 0 enabled, start=0x100, end=0x180, warp 2:
  - Stimulus: commit 0x100, then three commits of tmask 4'b1111 over 5 cycles, then 0x180 with tmask 4'b0011.
  - Response: win_active[0][2] rises the cycle after 0x100 and falls the cycle after 0x180; win_threads[0]=14; win_cycles[0]=cycles between those edges.
- Same cycle: channel 1 hits start and channel 4 hits end for the same warp/window → stays IDLE. With the window disabled, a start hit → no activation.
- Preload via long activity with CNT_W=8: win_threads saturates at 255 and holds. prof_clear with a simultaneous start hit → all zero next cycle and window IDLE.
- Assert reset low asynchronously between edges while windows are active → outputs zero immediately. After release, counting resumes from 0 on the next start hit.
